// File: rtl/gpio_shift_out_if.sv
// Bundle of the GPIO state input and the three-pin shift-register chain outputs.
// Latency: none (wiring only).
// Backpressure: none; the chain is driven open-loop.
interface gpio_shift_out_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] state;
  logic             ser;
  logic             srclk;
  logic             rclk;
  logic             busy;

  // GPIO/bench side: supplies state, observes the chain pins.
  modport master (
    output state,
    input  ser,
    input  srclk,
    input  rclk,
    input  busy
  );

  // Serialiser side: consumes state, drives the chain pins.
  modport slave (
    input  state,
    output ser,
    output srclk,
    output rclk,
    output busy
  );
endinterface

// File: rtl/gpio_shift_out.sv
// Serialises GPIO state MSB-first onto a 74HC595-style chain (ser/srclk/rclk).
// Latency: first srclk rise CLK_DIV+1 edges after a visible change; frame = 2*CLK_DIV*WIDTH+CLK_DIV cycles.
// Backpressure: none; state changes mid-frame are dropped except the last, which is re-sent afterwards.
module gpio_shift_out #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  gpio_shift_out_if.slave  bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] TOP_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] sent;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div;
  logic             init_pend;
  logic             ser_q;
  logic             srclk_q;
  logic             rclk_q;
  logic             busy_q;

  wire div_end = (div == DIV_MAX);

  // Frame sequencer: every output is a register so state never reaches a pin combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      snap      <= '0;
      sent      <= '0;
      bit_cnt   <= '0;
      div       <= '0;
      init_pend <= 1'b1;
      ser_q     <= 1'b0;
      srclk_q   <= 1'b0;
      rclk_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          // init_pend makes the external chain defined even when state matches the reset value of sent.
          if ((bus.state != sent) || init_pend) begin
            snap      <= bus.state;
            ser_q     <= bus.state[WIDTH-1];
            bit_cnt   <= TOP_BIT;
            div       <= '0;
            init_pend <= 1'b0;
            busy_q    <= 1'b1;
            fsm       <= SHIFT_LO;
          end else begin
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        SHIFT_LO: begin
          if (div_end) begin
            div     <= '0;
            srclk_q <= 1'b1;
            fsm     <= SHIFT_HI;
          end else begin
            div <= div + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (div_end) begin
            div     <= '0;
            srclk_q <= 1'b0;
            // ser only moves on the srclk falling edge, giving a full low phase of setup.
            if (bit_cnt == '0) begin
              ser_q  <= 1'b0;
              rclk_q <= 1'b1;
              fsm    <= LATCH;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              ser_q   <= snap[bit_cnt - 1'b1];
              fsm     <= SHIFT_LO;
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        LATCH: begin
          if (div_end) begin
            div    <= '0;
            rclk_q <= 1'b0;
            sent   <= snap;
            busy_q <= 1'b0;
            fsm    <= IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end

        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

  assign bus.ser   = ser_q;
  assign bus.srclk = srclk_q;
  assign bus.rclk  = rclk_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_gpio_shift_out.sv
// Bench for gpio_shift_out: default build plus a CLK_DIV=1/WIDTH=8 build.
// An external 74HC595 chain model turns the pin activity back into latched words.
module tb_gpio_shift_out;
  localparam int W     = 32;
  localparam int D     = 4;
  localparam int W2    = 8;
  localparam int D2    = 1;
  localparam int FRAME  = 2 * D * W + D;
  localparam int FRAME2 = 2 * D2 * W2 + D2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gpio_shift_out_if #(.WIDTH(W))  bif ();
  gpio_shift_out_if #(.WIDTH(W2)) bif2 ();

  gpio_shift_out #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  gpio_shift_out #(.WIDTH(W2), .CLK_DIV(D2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bif2.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // External chain model for the default build, sampled mid-cycle.
  logic [W-1:0] sr_model = '0;
  logic [W-1:0] latched[$];
  logic         ser_bits[$];
  int           busy_runs[$];
  int           gaps[$];
  int           rclk_widths[$];
  int busy_run = 0, idle_run = 0, rclk_run = 0;
  int srclk_rises = 0, rclk_rises = 0, setup_viol = 0;
  logic p_srclk = 1'b0, p_rclk = 1'b0, p_ser = 1'b0;

  always @(negedge clk) begin
    if (bif.busy === 1'b1) begin
      busy_run++;
      if (idle_run > 0) begin gaps.push_back(idle_run); idle_run = 0; end
    end else begin
      idle_run++;
      if (busy_run > 0) begin busy_runs.push_back(busy_run); busy_run = 0; end
    end
    if (bif.srclk && !p_srclk) begin
      sr_model = {sr_model[W-2:0], bif.ser};
      ser_bits.push_back(bif.ser);
      srclk_rises++;
      if (bif.ser !== p_ser) setup_viol++;
    end
    if (bif.srclk && p_srclk && (bif.ser !== p_ser)) setup_viol++;
    if (bif.rclk && !p_rclk) begin latched.push_back(sr_model); rclk_rises++; end
    if (bif.rclk) rclk_run++;
    else if (rclk_run > 0) begin rclk_widths.push_back(rclk_run); rclk_run = 0; end
    p_srclk = bif.srclk;
    p_rclk  = bif.rclk;
    p_ser   = bif.ser;
  end

  // Chain model for the narrow, undivided build.
  logic [W2-1:0] sr2 = '0;
  logic [W2-1:0] latched2[$];
  int busy2_runs[$];
  int busy2_run = 0, srclk2_rises = 0, bad_toggle = 0, hi2_run = 0, lo2_run = 0;
  logic p2_srclk = 1'b0, p2_rclk = 1'b0;

  always @(negedge clk) begin
    if (bif2.busy === 1'b1) busy2_run++;
    else if (busy2_run > 0) begin busy2_runs.push_back(busy2_run); busy2_run = 0; end
    if (bif2.srclk && !p2_srclk) begin
      sr2 = {sr2[W2-2:0], bif2.ser};
      srclk2_rises++;
      if (lo2_run != 1) bad_toggle++;
    end
    if (!bif2.srclk && p2_srclk && hi2_run != 1) bad_toggle++;
    if (bif2.srclk) begin hi2_run++; lo2_run = 0; end
    else if (bif2.busy === 1'b1) begin lo2_run++; hi2_run = 0; end
    else begin lo2_run = 0; hi2_run = 0; end
    if (bif2.rclk && !p2_rclk) latched2.push_back(sr2);
    p2_srclk = bif2.srclk;
    p2_rclk  = bif2.rclk;
  end

  // Bounded wait for three consecutive idle cycles on one of the two builds.
  task automatic wait_quiet(input int which, input string name);
    int  q;
    bit  ok;
    logic b;
    q  = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      b = (which == 1) ? bif2.busy : bif.busy;
      if (b === 1'b0) q++; else q = 0;
      if (q >= 3) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_quiet busy not idle after 2000 cycles, required idle", name); end
  endtask

  task automatic set_state(input logic [W-1:0] v);
    @(negedge clk);
    bif.state = v;
  endtask

  task automatic test_reset;
    int n_lat, n_rise, n_runs;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bif.ser !== 1'b0)   begin failures++; $display("FAIL rst_ser got=%b exp=0", bif.ser); end
    checks++; if (bif.srclk !== 1'b0) begin failures++; $display("FAIL rst_srclk got=%b exp=0", bif.srclk); end
    checks++; if (bif.rclk !== 1'b0)  begin failures++; $display("FAIL rst_rclk got=%b exp=0", bif.rclk); end
    checks++; if (bif.busy !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b exp=0", bif.busy); end
    n_lat  = latched.size();
    n_rise = srclk_rises;
    n_runs = busy_runs.size();
    @(negedge clk);
    rst = 1'b0;
    wait_quiet(0, "init");
    wait_quiet(1, "init2");
    checks++; if (busy_runs.size() - n_runs != 1) begin failures++; $display("FAIL init_frames got=%0d exp=1", busy_runs.size() - n_runs); end
    checks++; if (busy_runs[$] != FRAME) begin failures++; $display("FAIL init_busy_len got=%0d exp=%0d", busy_runs[$], FRAME); end
    checks++; if (srclk_rises - n_rise != W) begin failures++; $display("FAIL init_srclk_rises got=%0d exp=%0d", srclk_rises - n_rise, W); end
    checks++; if (latched.size() - n_lat != 1) begin failures++; $display("FAIL init_rclk_pulses got=%0d exp=1", latched.size() - n_lat); end
    checks++; if (rclk_widths[$] != D) begin failures++; $display("FAIL init_rclk_width got=%0d exp=%0d", rclk_widths[$], D); end
    checks++; if (latched[$] !== '0) begin failures++; $display("FAIL init_latched got=%h exp=00000000", latched[$]); end
    n_rise = srclk_rises;
    n_lat  = rclk_rises;
    n_runs = busy_runs.size();
    repeat (1000) @(negedge clk);
    checks++;
    if ((srclk_rises != n_rise) || (rclk_rises != n_lat) || (busy_runs.size() != n_runs) || (bif.busy !== 1'b0)) begin
      failures++;
      $display("FAIL idle_hold srclk_rises=%0d rclk_rises=%0d busy=%b, required no activity", srclk_rises - n_rise, rclk_rises - n_lat, bif.busy);
    end
  endtask

  task automatic test_pattern;
    logic [W-1:0] v;
    int n_bits, n_lat, edges, bad;
    bit found;
    v = 32'h8000_0001;
    n_bits = ser_bits.size();
    n_lat  = latched.size();
    set_state(v);
    edges = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bif.srclk === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found || edges != D + 1) begin failures++; $display("FAIL latency got=%0d edges exp=%0d", edges, D + 1); end
    wait_quiet(0, "pattern");
    bad = 0;
    for (int i = 0; i < W; i++)
      if ((n_bits + i >= ser_bits.size()) || (ser_bits[n_bits + i] !== v[W-1-i])) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL pattern_ser_bits wrong_bits=%0d exp=0", bad); end
    checks++; if (latched.size() - n_lat != 1 || latched[$] !== v) begin failures++; $display("FAIL pattern_latched got=%h exp=%h", latched[$], v); end
    checks++; if (busy_runs[$] != FRAME) begin failures++; $display("FAIL pattern_busy_len got=%0d exp=%0d", busy_runs[$], FRAME); end
  endtask

  task automatic test_back_to_back;
    int n_lat, n_runs, n_gaps;
    n_lat  = latched.size();
    n_runs = busy_runs.size();
    n_gaps = gaps.size();
    set_state(32'h1234_5678);
    repeat (100) @(negedge clk);
    bif.state = 32'hFFFF_0000;
    wait_quiet(0, "b2b");
    checks++;
    if ((latched.size() - n_lat != 2) || (latched[n_lat] !== 32'h1234_5678) || (latched[$] !== 32'hFFFF_0000)) begin
      failures++; $display("FAIL b2b_latched count=%0d last=%h exp=2 frames 12345678,ffff0000", latched.size() - n_lat, latched[$]);
    end
    checks++; if (gaps.size() - n_gaps != 2 || gaps[$] != 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=1", gaps[$]); end
    checks++;
    if ((busy_runs.size() - n_runs != 2) || (busy_runs[$] != FRAME) || (busy_runs[n_runs] != FRAME)) begin
      failures++; $display("FAIL b2b_busy_len runs=%0d last=%0d exp=2 runs of %0d", busy_runs.size() - n_runs, busy_runs[$], FRAME);
    end
  endtask

  task automatic test_return;
    int n_lat, n_runs;
    n_lat  = latched.size();
    n_runs = busy_runs.size();
    set_state(32'h0000_000F);
    repeat (20) @(negedge clk);
    bif.state = 32'h0000_00F0;
    repeat (20) @(negedge clk);
    bif.state = 32'h0000_000F;
    wait_quiet(0, "return");
    repeat (300) @(negedge clk);
    checks++; if (latched.size() - n_lat != 1) begin failures++; $display("FAIL return_pulses got=%0d exp=1", latched.size() - n_lat); end
    checks++; if (latched[$] !== 32'h0000_000F) begin failures++; $display("FAIL return_latched got=%h exp=0000000f", latched[$]); end
    checks++; if (busy_runs.size() - n_runs != 1 || bif.busy !== 1'b0) begin failures++; $display("FAIL return_busy frames=%0d busy=%b exp=1 frame then idle", busy_runs.size() - n_runs, bif.busy); end
  endtask

  task automatic test_reset_midframe;
    int n_lat, r0;
    set_state(32'hA5A5_A5A5);
    repeat (150) @(negedge clk);
    r0 = rclk_rises;
    n_lat = latched.size();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bif.ser, bif.srclk, bif.rclk, bif.busy} !== 4'b0000) begin
      failures++; $display("FAIL async_rst ser=%b srclk=%b rclk=%b busy=%b exp all 0", bif.ser, bif.srclk, bif.rclk, bif.busy);
    end
    repeat (3) @(negedge clk);
    checks++; if (rclk_rises != r0) begin failures++; $display("FAIL partial_latch got=%0d pulses exp=0", rclk_rises - r0); end
    rst = 1'b0;
    wait_quiet(0, "rst_mid");
    wait_quiet(1, "rst_mid2");
    checks++; if (latched.size() - n_lat != 1 || latched[$] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL rst_mid_latched got=%h exp=a5a5a5a5", latched[$]); end
    checks++; if (busy_runs[$] != FRAME) begin failures++; $display("FAIL rst_mid_busy_len got=%0d exp=%0d", busy_runs[$], FRAME); end
  endtask

  task automatic test_random;
    logic [W-1:0] v1, v2, model_sent;
    logic [W-1:0] e[2];
    int exp_n, n_lat, k, bad;
    model_sent = 32'hA5A5_A5A5;
    for (int it = 0; it < 6; it++) begin
      v1 = $urandom;
      v2 = ($urandom_range(0, 3) == 0) ? v1 : $urandom;
      k  = $urandom_range(5, 240);
      exp_n = 0;
      // Last-value-wins: a frame for v1 if it differs, then one for v2 if it differs from what is latched.
      if (v1 != model_sent) begin e[exp_n] = v1; exp_n++; model_sent = v1; end
      if (v2 != model_sent) begin e[exp_n] = v2; exp_n++; model_sent = v2; end
      n_lat = latched.size();
      set_state(v1);
      repeat (k) @(negedge clk);
      bif.state = v2;
      wait_quiet(0, "random");
      bad = 0;
      if (latched.size() - n_lat != exp_n) bad++;
      else for (int j = 0; j < exp_n; j++) if (latched[n_lat + j] !== e[j]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL random_%0d frames=%0d exp=%0d last=%h exp_last=%h", it, latched.size() - n_lat, exp_n, latched[$], model_sent); end
    end
    checks++; if (setup_viol != 0) begin failures++; $display("FAIL ser_stability violations=%0d exp=0", setup_viol); end
  endtask

  task automatic test_clkdiv1;
    int n_rise, n_bad, n_lat;
    n_rise = srclk2_rises;
    n_bad  = bad_toggle;
    n_lat  = latched2.size();
    @(negedge clk);
    bif2.state = 8'hC3;
    wait_quiet(1, "div1");
    checks++; if (busy2_runs[$] != FRAME2) begin failures++; $display("FAIL div1_busy_len got=%0d exp=%0d", busy2_runs[$], FRAME2); end
    checks++; if (srclk2_rises - n_rise != W2) begin failures++; $display("FAIL div1_srclk_rises got=%0d exp=%0d", srclk2_rises - n_rise, W2); end
    checks++; if (bad_toggle != n_bad) begin failures++; $display("FAIL div1_toggle bad_phases=%0d exp=0", bad_toggle - n_bad); end
    checks++; if (latched2.size() - n_lat != 1 || latched2[$] !== 8'hC3) begin failures++; $display("FAIL div1_latched got=%h exp=c3", latched2[$]); end
  endtask

  initial begin
    bif.state  = '0;
    bif2.state = '0;
    test_reset();
    test_pattern();
    test_back_to_back();
    test_return();
    test_reset_midframe();
    test_random();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation exceeded 90000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
